// File: rtl/aha_tlx_fwd_pkg.sv
// Shared frame geometry, header codes and PRBS-7 helpers for the TLX forward
// lane serializer.
package aha_tlx_fwd_pkg;

  localparam int unsigned FRAME_W = 42;
  localparam int unsigned BODY_W  = 40;

  localparam logic [1:0] HDR_IDLE    = 2'b00;
  localparam logic [1:0] HDR_PAYLOAD = 2'b01;
  localparam logic [1:0] HDR_FLOW    = 2'b10;
  localparam logic [1:0] HDR_TRAIN   = 2'b11;

  localparam logic [BODY_W-1:0] TRAIN_FIXED_PATTERN = 40'hA5A5A5A5A5;

  // x^7 + x^6 + 1: feedback is state[6] ^ state[5]
  localparam logic [6:0] PRBS7_SEED = 7'h7F;
  localparam logic [6:0] PRBS7_TAPS = 7'h60;

  typedef enum logic [1:0] {
    FRAME_IDLE,
    FRAME_PAYLOAD,
    FRAME_FLOW,
    FRAME_TRAIN
  } frame_kind_e;

  typedef struct packed {
    logic [6:0]        state;
    logic [BODY_W-1:0] body;
  } prbs7_step_t;

  // First generated bit lands in the body MSB so it leaves the lane first.
  function automatic prbs7_step_t prbs7_advance(input logic [6:0] start);
    prbs7_step_t r;
    logic [6:0]  s;
    logic        b;
    s      = start;
    r.body = '0;
    for (int unsigned i = 0; i < BODY_W; i++) begin
      b                  = ^(s & PRBS7_TAPS);
      r.body[BODY_W-1-i] = b;
      s                  = {s[5:0], b};
    end
    r.state = s;
    return r;
  endfunction

endpackage

// File: rtl/aha_tlx_fwd_prbs7.sv
// PRBS-7 training-body generator: produces 40 LFSR bits per advance, with a
// reseed control that restarts the sequence from PRBS7_SEED.
module aha_tlx_fwd_prbs7
  import aha_tlx_fwd_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              reseed_i,
  input  logic              advance_i,
  output logic [BODY_W-1:0] body_o
);

  logic [6:0]  state_q, state_d;
  logic [6:0]  base;
  prbs7_step_t step;

  // Reseed and advance in the same cycle emit the body that starts at the seed.
  always_comb begin
    base    = reseed_i ? PRBS7_SEED : state_q;
    step    = prbs7_advance(base);
    body_o  = step.body;
    state_d = state_q;
    if (advance_i) begin
      state_d = step.state;
    end else if (reseed_i) begin
      state_d = PRBS7_SEED;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= PRBS7_SEED;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/aha_tlx_fwd_lane_serializer.sv
// TLX forward-channel lane serializer: frames payload/flow/idle/training items
// into 42-bit frames and shifts them out LANE_W bits per cycle, header first.
// Optional macro TLX_FWD_PRBS_TRAIN_EN selects a PRBS-7 training body.
module aha_tlx_fwd_lane_serializer
  import aha_tlx_fwd_pkg::*;
#(
  parameter int unsigned LANE_W         = 6,
  parameter int unsigned FLOW_BURST_MAX = 4
) (
  input  logic              TLX_FWD_CLK,
  input  logic              TLX_FWD_RESETn,
  input  logic              TLX_FWD_PAYLOAD_TVALID,
  output logic              TLX_FWD_PAYLOAD_TREADY,
  input  logic [39:0]       TLX_FWD_PAYLOAD_TDATA,
  input  logic              TLX_FWD_FLOW_TVALID,
  output logic              TLX_FWD_FLOW_TREADY,
  input  logic [1:0]        TLX_FWD_FLOW_TDATA,
  input  logic              TLX_FWD_TRAIN_EN,
  output logic [LANE_W-1:0] TLX_FWD_LANE_DATA,
  output logic              TLX_FWD_LANE_SOF,
  output logic              TLX_FWD_TRAIN_ACTIVE
);

  localparam int unsigned      BEATS     = FRAME_W / LANE_W;
  localparam int unsigned      CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [3:0]       RUN_MAX   = 4'(FLOW_BURST_MAX);

  if ((FRAME_W % LANE_W) != 0) begin : g_bad_lane_w
    $error("LANE_W must divide 42");
  end
  if ((FLOW_BURST_MAX < 1) || (FLOW_BURST_MAX > 15)) begin : g_bad_burst
    $error("FLOW_BURST_MAX must be in 1..15");
  end

  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic               sof_q, sof_d;
  logic               train_q, train_d;
  logic [3:0]         flow_run_q, flow_run_d;

  logic               load;
  frame_kind_e        kind;
  logic [BODY_W-1:0]  train_body;
  logic [FRAME_W-1:0] frame;

`ifdef TLX_FWD_PRBS_TRAIN_EN
  logic train_prev_q;
  logic prbs_reseed;
  logic prbs_advance;

  assign prbs_reseed  = load && TLX_FWD_TRAIN_EN && !train_prev_q;
  assign prbs_advance = load && (kind == FRAME_TRAIN);

  aha_tlx_fwd_prbs7 u_prbs7 (
    .clk_i     (TLX_FWD_CLK),
    .rst_ni    (TLX_FWD_RESETn),
    .reseed_i  (prbs_reseed),
    .advance_i (prbs_advance),
    .body_o    (train_body)
  );

  always_ff @(posedge TLX_FWD_CLK or negedge TLX_FWD_RESETn) begin
    if (!TLX_FWD_RESETn) begin
      train_prev_q <= 1'b0;
    end else if (load) begin
      train_prev_q <= TLX_FWD_TRAIN_EN;
    end
  end
`else
  assign train_body = TRAIN_FIXED_PATTERN;
`endif

  // beat_cnt resets to the last beat, so the first cycle after release loads.
  assign load = (beat_cnt_q == LAST_BEAT);

  always_comb begin
    kind = FRAME_IDLE;
    if (TLX_FWD_TRAIN_EN) begin
      kind = FRAME_TRAIN;
    end else if (TLX_FWD_FLOW_TVALID &&
                 !((flow_run_q == RUN_MAX) && TLX_FWD_PAYLOAD_TVALID)) begin
      kind = FRAME_FLOW;
    end else if (TLX_FWD_PAYLOAD_TVALID) begin
      kind = FRAME_PAYLOAD;
    end
  end

  always_comb begin
    frame = '0;
    case (kind)
      FRAME_PAYLOAD: frame = {HDR_PAYLOAD, TLX_FWD_PAYLOAD_TDATA};
      FRAME_FLOW:    frame = {HDR_FLOW, 38'b0, TLX_FWD_FLOW_TDATA};
      FRAME_TRAIN:   frame = {HDR_TRAIN, train_body};
      default:       frame = {HDR_IDLE, {BODY_W{1'b0}}};
    endcase
  end

  always_comb begin
    beat_cnt_d = beat_cnt_q + CNT_W'(1);
    shreg_d    = shreg_q << LANE_W;
    sof_d      = 1'b0;
    train_d    = train_q;
    flow_run_d = flow_run_q;
    if (load) begin
      beat_cnt_d = '0;
      shreg_d    = frame;
      sof_d      = 1'b1;
      train_d    = (kind == FRAME_TRAIN);
      if (kind == FRAME_FLOW) begin
        flow_run_d = (flow_run_q == RUN_MAX) ? RUN_MAX : flow_run_q + 4'd1;
      end else begin
        flow_run_d = '0;
      end
    end
  end

  always_ff @(posedge TLX_FWD_CLK or negedge TLX_FWD_RESETn) begin
    if (!TLX_FWD_RESETn) begin
      beat_cnt_q <= LAST_BEAT;
      shreg_q    <= '0;
      sof_q      <= 1'b0;
      train_q    <= 1'b0;
      flow_run_q <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      shreg_q    <= shreg_d;
      sof_q      <= sof_d;
      train_q    <= train_d;
      flow_run_q <= flow_run_d;
    end
  end

  // Handshakes are combinational; the reset term keeps them low while held in reset.
  assign TLX_FWD_PAYLOAD_TREADY = TLX_FWD_RESETn && load && (kind == FRAME_PAYLOAD);
  assign TLX_FWD_FLOW_TREADY    = TLX_FWD_RESETn && load && (kind == FRAME_FLOW);
  assign TLX_FWD_LANE_DATA      = shreg_q[FRAME_W-1 -: LANE_W];
  assign TLX_FWD_LANE_SOF       = sof_q;
  assign TLX_FWD_TRAIN_ACTIVE   = train_q;

endmodule

// File: tb/tb_aha_tlx_fwd_lane_serializer.sv
// Directed self-checking bench for aha_tlx_fwd_lane_serializer (LANE_W=6 and 42).
module tb_aha_tlx_fwd_lane_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pv, fv, train_en;
  logic [39:0] pd;
  logic [1:0]  fd;
  logic        p_rdy, f_rdy, sof, tr_act;
  logic [5:0]  lane;

  logic        pv42;
  logic [39:0] pd42;
  logic        p_rdy42, f_rdy42, sof42, tr_act42;
  logic [41:0] lane42;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  logic [5:0] pay_beats [7] = '{6'h11, 6'h08, 6'h34, 6'h15, 6'h27, 6'h22, 6'h1A};
  logic [5:0] ofs_beats [7] = '{6'h10, 6'h3C, 6'h0F, 6'h03, 6'h30, 6'h3C, 6'h0F};

  always #5 clk = ~clk;

  aha_tlx_fwd_lane_serializer #(.LANE_W(6), .FLOW_BURST_MAX(4)) dut (
    .TLX_FWD_CLK            (clk),
    .TLX_FWD_RESETn         (rst_n),
    .TLX_FWD_PAYLOAD_TVALID (pv),
    .TLX_FWD_PAYLOAD_TREADY (p_rdy),
    .TLX_FWD_PAYLOAD_TDATA  (pd),
    .TLX_FWD_FLOW_TVALID    (fv),
    .TLX_FWD_FLOW_TREADY    (f_rdy),
    .TLX_FWD_FLOW_TDATA     (fd),
    .TLX_FWD_TRAIN_EN       (train_en),
    .TLX_FWD_LANE_DATA      (lane),
    .TLX_FWD_LANE_SOF       (sof),
    .TLX_FWD_TRAIN_ACTIVE   (tr_act)
  );

  aha_tlx_fwd_lane_serializer #(.LANE_W(42), .FLOW_BURST_MAX(4)) dut42 (
    .TLX_FWD_CLK            (clk),
    .TLX_FWD_RESETn         (rst_n),
    .TLX_FWD_PAYLOAD_TVALID (pv42),
    .TLX_FWD_PAYLOAD_TREADY (p_rdy42),
    .TLX_FWD_PAYLOAD_TDATA  (pd42),
    .TLX_FWD_FLOW_TVALID    (1'b0),
    .TLX_FWD_FLOW_TREADY    (f_rdy42),
    .TLX_FWD_FLOW_TDATA     (2'b00),
    .TLX_FWD_TRAIN_EN       (1'b0),
    .TLX_FWD_LANE_DATA      (lane42),
    .TLX_FWD_LANE_SOF       (sof42),
    .TLX_FWD_TRAIN_ACTIVE   (tr_act42)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit into cycle 0 (first load cycle after release).
  task automatic do_reset();
    pv = 1'b0; fv = 1'b0; train_en = 1'b0; pd = '0; fd = '0;
    pv42 = 1'b0; pd42 = '0;
    next_cycle();
    rst_n = 1'b0;
    repeat (2) next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pv = 1'b1; fv = 1'b1; train_en = 1'b0; pd = 40'hFF_FFFF_FFFF; fd = 2'b11;
    pv42 = 1'b1; pd42 = '1;
    repeat (2) @(negedge clk);
    n_cmp++; if (lane !== 6'h00) begin n_fail++; $display("FAIL reset_lane: got %h want 00", lane); end
    n_cmp++; if (sof !== 1'b0) begin n_fail++; $display("FAIL reset_sof: got %b want 0", sof); end
    n_cmp++; if (tr_act !== 1'b0) begin n_fail++; $display("FAIL reset_train: got %b want 0", tr_act); end
    n_cmp++; if (p_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_prdy: got %b want 0", p_rdy); end
    n_cmp++; if (f_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_frdy: got %b want 0", f_rdy); end
    n_cmp++; if (p_rdy42 !== 1'b0) begin n_fail++; $display("FAIL reset_prdy42: got %b want 0", p_rdy42); end
  endtask

  task automatic test_idle();
    do_reset();
    for (int c = 0; c <= 21; c++) begin
      if (c > 0) next_cycle();
      @(negedge clk);
      n_cmp++;
      if (sof !== ((c % 7) == 1)) begin
        n_fail++; $display("FAIL idle_sof c%0d: got %b want %b", c, sof, (c % 7) == 1);
      end
      n_cmp++;
      if (lane !== 6'h00 || p_rdy !== 1'b0 || f_rdy !== 1'b0 || tr_act !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_out c%0d: got lane=%h prdy=%b frdy=%b tr=%b want 00/0/0/0",
                 c, lane, p_rdy, f_rdy, tr_act);
      end
    end
  endtask

  task automatic test_single_payload();
    do_reset();
    pv = 1'b1; pd = 40'h12_3456_789A;
    @(negedge clk);
    n_cmp++; if (p_rdy !== 1'b1) begin n_fail++; $display("FAIL pay_rdy: got %b want 1", p_rdy); end
    n_cmp++; if (f_rdy !== 1'b0) begin n_fail++; $display("FAIL pay_frdy: got %b want 0", f_rdy); end
    for (int c = 1; c <= 8; c++) begin
      next_cycle();
      if (c == 1) pv = 1'b0;
      @(negedge clk);
      if (c <= 7) begin
        n_cmp++;
        if (lane !== pay_beats[c-1] || sof !== (c == 1)) begin
          n_fail++;
          $display("FAIL pay_beat%0d: got %h sof=%b want %h sof=%b", c - 1, lane, sof,
                   pay_beats[c-1], c == 1);
        end
        n_cmp++;
        if (p_rdy !== 1'b0) begin n_fail++; $display("FAIL pay_rdy_beat%0d: got %b want 0", c - 1, p_rdy); end
      end else begin
        n_cmp++;
        if (lane !== 6'h00 || sof !== 1'b1) begin
          n_fail++; $display("FAIL pay_next_idle: got %h sof=%b want 00 sof=1", lane, sof);
        end
      end
    end
  endtask

  task automatic test_flow_burst();
    logic want_pay;
    logic prev_pay;
    do_reset();
    fv = 1'b1; fd = 2'b11; pv = 1'b1; pd = 40'hFF_FFFF_FFC5;
    prev_pay = 1'b0;
    for (int f = 0; f < 12; f++) begin
      want_pay = ((f % 5) == 4);
      @(negedge clk);
      if (f > 0) begin
        n_cmp++;
        if (lane !== (prev_pay ? 6'h05 : 6'h03)) begin
          n_fail++; $display("FAIL burst_last_beat f%0d: got %h want %h", f - 1, lane,
                               prev_pay ? 6'h05 : 6'h03);
        end
      end
      n_cmp++;
      if (f_rdy !== !want_pay || p_rdy !== want_pay) begin
        n_fail++; $display("FAIL burst_rdy f%0d: got frdy=%b prdy=%b want frdy=%b prdy=%b",
                             f, f_rdy, p_rdy, !want_pay, want_pay);
      end
      next_cycle();
      @(negedge clk);
      n_cmp++;
      if (sof !== 1'b1 || lane[5:4] !== (want_pay ? 2'b01 : 2'b10)) begin
        n_fail++; $display("FAIL burst_hdr f%0d: got hdr=%b sof=%b want hdr=%b sof=1",
                             f, lane[5:4], sof, want_pay ? 2'b01 : 2'b10);
      end
      prev_pay = want_pay;
      repeat (6) next_cycle();
    end
    fv = 1'b0; pv = 1'b0;
  endtask

  task automatic test_train_midframe();
    logic [41:0] exp_tr;
`ifdef TLX_FWD_PRBS_TRAIN_EN
    logic [6:0] s;
    logic       b;
    s = 7'h7F;
    exp_tr = {2'b11, 40'h0};
    for (int i = 0; i < 40; i++) begin
      b = s[6] ^ s[5];
      exp_tr[39 - i] = b;
      s = {s[5:0], b};
    end
`else
    exp_tr = {2'b11, 40'hA5_A5A5_A5A5};
`endif
    do_reset();
    pv = 1'b1; pd = 40'h0F_0F0F_0F0F;
    @(negedge clk);
    n_cmp++; if (p_rdy !== 1'b1) begin n_fail++; $display("FAIL tr_pay_rdy: got %b want 1", p_rdy); end
    for (int c = 1; c <= 15; c++) begin
      next_cycle();
      if (c == 1) pv = 1'b0;
      if (c == 3) begin train_en = 1'b1; pv = 1'b1; fv = 1'b1; end
      if (c == 10) begin train_en = 1'b0; pv = 1'b0; fv = 1'b0; end
      @(negedge clk);
      n_cmp++;
      if (p_rdy !== 1'b0 || f_rdy !== 1'b0) begin
        n_fail++; $display("FAIL tr_rdy c%0d: got prdy=%b frdy=%b want 0/0", c, p_rdy, f_rdy);
      end
      if (c <= 7) begin
        n_cmp++;
        if (lane !== ofs_beats[c-1] || tr_act !== 1'b0) begin
          n_fail++; $display("FAIL tr_pay_beat%0d: got %h tr=%b want %h tr=0", c - 1, lane,
                               tr_act, ofs_beats[c-1]);
        end
      end else if (c <= 14) begin
        n_cmp++;
        if (lane !== exp_tr[41 - (c - 8) * 6 -: 6] || tr_act !== 1'b1 || sof !== (c == 8)) begin
          n_fail++; $display("FAIL tr_beat%0d: got %h tr=%b sof=%b want %h tr=1 sof=%b", c - 8,
                               lane, tr_act, sof, exp_tr[41 - (c - 8) * 6 -: 6], c == 8);
        end
      end else begin
        n_cmp++;
        if (lane !== 6'h00 || tr_act !== 1'b0 || sof !== 1'b1) begin
          n_fail++; $display("FAIL tr_after: got %h tr=%b sof=%b want 00 tr=0 sof=1", lane, tr_act, sof);
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    int unsigned acc;
    do_reset();
    pv = 1'b1; pd = 40'h12_3456_789A;
    @(negedge clk);
    n_cmp++; if (p_rdy !== 1'b1) begin n_fail++; $display("FAIL rm_first_rdy: got %b want 1", p_rdy); end
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      if (c == 1) pv = 1'b0;
      @(negedge clk);
    end
    n_cmp++; if (lane !== 6'h15) begin n_fail++; $display("FAIL rm_beat3: got %h want 15", lane); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (lane !== 6'h00 || sof !== 1'b0 || tr_act !== 1'b0) begin
      n_fail++; $display("FAIL rm_async: got %h sof=%b tr=%b want 00/0/0", lane, sof, tr_act);
    end
    pv = 1'b1;
    #1;
    n_cmp++; if (p_rdy !== 1'b0) begin n_fail++; $display("FAIL rm_rdy_in_reset: got %b want 0", p_rdy); end
    repeat (2) next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (p_rdy !== 1'b1) begin n_fail++; $display("FAIL rm_rdy_after: got %b want 1", p_rdy); end
    acc = 1;
    for (int c = 1; c <= 8; c++) begin
      next_cycle();
      if (c == 1) pv = 1'b0;
      @(negedge clk);
      if (p_rdy === 1'b1) acc++;
      if (c <= 7) begin
        n_cmp++;
        if (lane !== pay_beats[c-1] || sof !== (c == 1)) begin
          n_fail++; $display("FAIL rm_beat%0d: got %h sof=%b want %h sof=%b", c - 1, lane, sof,
                               pay_beats[c-1], c == 1);
        end
      end else begin
        n_cmp++;
        if (lane !== 6'h00 || sof !== 1'b1) begin
          n_fail++; $display("FAIL rm_next_idle: got %h sof=%b want 00 sof=1", lane, sof);
        end
      end
    end
    n_cmp++; if (acc !== 1) begin n_fail++; $display("FAIL rm_accept_count: got %0d want 1", acc); end
  endtask

  task automatic test_lane42();
    logic [39:0] prev;
    do_reset();
    pv42 = 1'b1; pd42 = 40'hA0_0000_0000;
    @(negedge clk);
    n_cmp++;
    if (p_rdy42 !== 1'b1 || sof42 !== 1'b0) begin
      n_fail++; $display("FAIL l42_first: got rdy=%b sof=%b want 1/0", p_rdy42, sof42);
    end
    for (int c = 1; c <= 4; c++) begin
      prev = pd42;
      next_cycle();
      pd42 = 40'hA0_0000_0000 | 40'(c);
      if (c == 4) pv42 = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (sof42 !== 1'b1 || lane42 !== {2'b01, prev}) begin
        n_fail++; $display("FAIL l42_frame%0d: got %h sof=%b want %h sof=1", c, lane42, sof42,
                             {2'b01, prev});
      end
      n_cmp++;
      if (p_rdy42 !== (c != 4)) begin
        n_fail++; $display("FAIL l42_rdy%0d: got %b want %b", c, p_rdy42, c != 4);
      end
    end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if (sof42 !== 1'b1 || lane42 !== 42'h0) begin
      n_fail++; $display("FAIL l42_idle: got %h sof=%b want 0 sof=1", lane42, sof42);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single_payload();
    test_flow_burst();
    test_train_midframe();
    test_reset_midframe();
    test_lane42();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
